// File: rtl/fetch_sequencer.sv
// Instruction-cycle sequencer for the basic computer: steps fetch, decode and the
// optional indirect resolution, then hands each instruction to the execute unit.
module fetch_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] ir_in,
    input  logic              exec_done,
    input  logic              halt,
    output logic [2:0]        bus_sel,
    output logic              mem_read,
    output logic              ar_load,
    output logic              ar_inc,
    output logic              ar_clr,
    output logic              pc_load,
    output logic              pc_inc,
    output logic              pc_clr,
    output logic              ir_load,
    output logic              i_flag,
    output logic [2:0]        opcode,
    output logic              exec_start,
    output logic [3:0]        sc,
    output logic              running
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_T0   = 3'd2,
        S_T1   = 3'd3,
        S_T2   = 3'd4,
        S_T3   = 3'd5,
        S_EXEC = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  sc_q, sc_d;
    logic        i_flag_q, i_flag_d;
    logic [2:0]  opcode_q, opcode_d;

    // The address field of IR is routed over the bus, never decoded here.
    logic        unused_addr_s;
    assign unused_addr_s = ^ir_in[ADDR_W-1:0];

    // State, timing count and latched instruction fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sc_q     <= 4'd0;
            i_flag_q <= 1'b0;
            opcode_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            sc_q     <= sc_d;
            i_flag_q <= i_flag_d;
            opcode_q <= opcode_d;
        end
    end

    // Next-state, next timing count (value the count takes in the next state).
    always_comb begin
        state_d  = state_q;
        sc_d     = sc_q;
        i_flag_d = i_flag_q;
        opcode_d = opcode_q;
        case (state_q)
            S_IDLE: begin
                sc_d = 4'd0;
                if (start) begin
                    state_d = S_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                state_d = S_T0;
                sc_d    = 4'd0;
            end
            S_T0: begin
                state_d = S_T1;
                sc_d    = 4'd1;
            end
            S_T1: begin
                state_d = S_T2;
                sc_d    = 4'd2;
            end
            S_T2: begin
                state_d  = S_T3;
                sc_d     = 4'd3;
                i_flag_d = ir_in[DATA_W-1];
                opcode_d = ir_in[DATA_W-2:DATA_W-4];
            end
            S_T3: begin
                state_d = S_EXEC;
                sc_d    = 4'd4;
            end
            S_EXEC: begin
                if (exec_done) begin
                    sc_d = 4'd0;
                    if (halt) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_T0;
                    end
                end else if (sc_q == 4'd15) begin
                    sc_d = 4'd15;
                end else begin
                    sc_d = sc_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                sc_d    = 4'd0;
            end
        endcase
    end

    // Moore control decode from the current state and latched fields.
    always_comb begin
        bus_sel    = 3'd0;
        mem_read   = 1'b0;
        ar_load    = 1'b0;
        ar_inc     = 1'b0;
        ar_clr     = 1'b0;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_clr     = 1'b0;
        ir_load    = 1'b0;
        exec_start = 1'b0;
        case (state_q)
            S_INIT: begin
                pc_clr = 1'b1;
                ar_clr = 1'b1;
            end
            S_T0: begin
                bus_sel = 3'd2;
                ar_load = 1'b1;
            end
            S_T1: begin
                bus_sel  = 3'd7;
                mem_read = 1'b1;
                ir_load  = 1'b1;
                pc_inc   = 1'b1;
            end
            S_T2: begin
                bus_sel = 3'd5;
                ar_load = 1'b1;
            end
            S_T3: begin
                // Register/IO references (opcode 7) never take the indirect fetch.
                if (i_flag_q && (opcode_q != 3'd7)) begin
                    bus_sel  = 3'd7;
                    mem_read = 1'b1;
                    ar_load  = 1'b1;
                end else begin
                    bus_sel  = 3'd0;
                end
            end
            S_EXEC: begin
                // The count is 4 only in the first EXEC cycle, since it never wraps.
                exec_start = (sc_q == 4'd4);
            end
            default: begin
                bus_sel = 3'd0;
            end
        endcase
    end

    assign i_flag  = i_flag_q;
    assign opcode  = opcode_q;
    assign sc      = sc_q;
    assign running = (state_q != S_IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a cycle model pushes the expected output
// vector before each edge; it is popped and compared just after the edge.
module tb_fetch_sequencer;

    localparam int P_IDLE = 0, P_INIT = 1, P_T0 = 2, P_T1 = 3, P_T2 = 4, P_T3 = 5, P_EXEC = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] ir_in = 16'h0000;
    logic        exec_done = 1'b0;
    logic        halt = 1'b0;
    logic [2:0]  bus_sel;
    logic        mem_read, ar_load, ar_inc, ar_clr, pc_load, pc_inc, pc_clr, ir_load;
    logic        i_flag, exec_start, running;
    logic [2:0]  opcode;
    logic [3:0]  sc;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int         m_ph = P_IDLE;
    logic       m_i = 1'b0;
    logic [2:0] m_op = 3'd0;
    int         m_sc = 0;
    bit         m_first = 1'b0;

    logic [20:0] exp_q[$];

    fetch_sequencer #(.DATA_W(16), .ADDR_W(12)) dut (
        .clk(clk), .reset(reset), .start(start), .ir_in(ir_in),
        .exec_done(exec_done), .halt(halt), .bus_sel(bus_sel), .mem_read(mem_read),
        .ar_load(ar_load), .ar_inc(ar_inc), .ar_clr(ar_clr),
        .pc_load(pc_load), .pc_inc(pc_inc), .pc_clr(pc_clr), .ir_load(ir_load),
        .i_flag(i_flag), .opcode(opcode), .exec_start(exec_start), .sc(sc),
        .running(running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [20:0] obs_vec();
        return {bus_sel, mem_read, ar_load, ar_inc, ar_clr, pc_load, pc_inc, pc_clr,
                ir_load, i_flag, opcode, exec_start, sc, running};
    endfunction

    function automatic logic [20:0] model_vec();
        logic [2:0] bs;
        logic mr, arl, arc, pci, pcc, irl, es;
        bs = 3'd0; mr = 1'b0; arl = 1'b0; arc = 1'b0;
        pci = 1'b0; pcc = 1'b0; irl = 1'b0; es = 1'b0;
        case (m_ph)
            P_INIT: begin arc = 1'b1; pcc = 1'b1; end
            P_T0:   begin bs = 3'd2; arl = 1'b1; end
            P_T1:   begin bs = 3'd7; mr = 1'b1; irl = 1'b1; pci = 1'b1; end
            P_T2:   begin bs = 3'd5; arl = 1'b1; end
            P_T3:   if (m_i && m_op != 3'd7) begin bs = 3'd7; mr = 1'b1; arl = 1'b1; end
            P_EXEC: es = m_first;
            default: ;
        endcase
        return {bs, mr, arl, 1'b0, arc, 1'b0, pci, pcc, irl, m_i, m_op, es,
                4'(m_sc), (m_ph != P_IDLE)};
    endfunction

    // Advance the model with the inputs now applied, then clock and compare.
    task automatic tick();
        if (reset) begin
            m_ph = P_IDLE; m_i = 1'b0; m_op = 3'd0; m_sc = 0; m_first = 1'b0;
        end else begin
            case (m_ph)
                P_IDLE: if (start) m_ph = P_INIT;
                P_INIT: m_ph = P_T0;
                P_T0:   begin m_ph = P_T1; m_sc = 1; end
                P_T1:   begin m_ph = P_T2; m_sc = 2; end
                P_T2:   begin m_ph = P_T3; m_sc = 3; m_i = ir_in[15]; m_op = ir_in[14:12]; end
                P_T3:   begin m_ph = P_EXEC; m_sc = 4; m_first = 1'b1; end
                P_EXEC: begin
                    m_first = 1'b0;
                    if (exec_done) begin
                        m_sc = 0;
                        m_ph = halt ? P_IDLE : P_T0;
                    end else if (m_sc < 15) begin
                        m_sc = m_sc + 1;
                    end
                end
                default: m_ph = P_IDLE;
            endcase
        end
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            check("outputs", 32'(obs_vec()), 32'(exp_q.pop_front()));
        end
        check("ar_excl", 32'($countones({ar_load, ar_inc, ar_clr}) <= 1), 32'd1);
        check("pc_excl", 32'($countones({pc_load, pc_inc, pc_clr}) <= 1), 32'd1);
    endtask

    initial begin
        int t0_cyc;
        int instr;
        int prev;

        reset = 1'b1;
        tick();
        check("reset_state", 32'(obs_vec()), 32'd0);
        reset = 1'b0;
        start = 1'b1;
        tick();
        check("init_clr", 32'({pc_clr, ar_clr}), 32'd3);
        start = 1'b0;
        tick();
        check("t0_bus", 32'({bus_sel, ar_load}), 32'({3'd2, 1'b1}));
        t0_cyc = cyc;
        ir_in = 16'h2123;
        tick();
        check("t1_ctrl", 32'({bus_sel, mem_read, ir_load, pc_inc}), 32'({3'd7, 3'b111}));
        tick();
        check("t2_bus", 32'({bus_sel, ar_load}), 32'({3'd5, 1'b1}));
        exec_done = 1'b1;
        tick();
        check("direct_flags", 32'({i_flag, opcode}), 32'h2);
        check("direct_t3", 32'({bus_sel, mem_read, ar_load}), 32'd0);
        tick();
        check("exec_start", 32'({exec_start, sc}), 32'({1'b1, 4'd4}));
        tick();
        check("exec_start_1cyc", 32'(exec_start), 32'd0);
        check("instr_len", 32'(cyc - t0_cyc), 32'd5);
        check("t0_sc", 32'(sc), 32'd0);

        // Indirect instruction, then a long EXEC that saturates the count.
        exec_done = 1'b0;
        ir_in = 16'h9ABC;
        tick(); tick(); tick();
        check("ind_flags", 32'({i_flag, opcode}), 32'h9);
        check("ind_t3", 32'({bus_sel, mem_read, ar_load}), 32'({3'd7, 2'b11}));
        for (int k = 0; k < 20; k++) begin
            tick();
            check("exec_sc", 32'(sc), (k + 4 > 15) ? 32'd15 : 32'(k + 4));
            check("exec_start_once", 32'(exec_start), (k == 0) ? 32'd1 : 32'd0);
            check("exec_no_ctrl", 32'({ar_load, ar_inc, ar_clr, pc_load, pc_inc, pc_clr}), 32'd0);
        end
        exec_done = 1'b1;
        halt = 1'b1;
        tick();
        check("halt_idle", 32'(running), 32'd0);
        halt = 1'b0;
        exec_done = 1'b0;

        // Register-reference instruction: indirect bit set but no T3 load.
        start = 1'b1;
        tick();
        start = 1'b0;
        ir_in = 16'hF800;
        tick(); tick(); tick(); tick();
        check("reg_flags", 32'({i_flag, opcode}), 32'hF);
        check("reg_t3", 32'({bus_sel, mem_read, ar_load}), 32'd0);
        exec_done = 1'b1;
        tick(); tick(); tick();
        check("pre_reset_t1", 32'(pc_inc), 32'd1);
        reset = 1'b1;
        tick();
        check("reset_t1", 32'(obs_vec()), 32'd0);
        reset = 1'b0;
        tick();
        check("after_reset_t1", 32'({pc_inc, running}), 32'd0);

        // Reset while in EXEC.
        exec_done = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick(); tick(); tick();
        check("in_exec", 32'(sc), 32'd5);
        exec_done = 1'b1;
        reset = 1'b1;
        tick();
        check("reset_exec", 32'(obs_vec()), 32'd0);
        reset = 1'b0;
        tick();
        check("after_reset_exec", 32'({exec_start, running}), 32'd0);

        // Random run of 1000 instructions.
        start = 1'b1;
        tick();
        start = 1'b0;
        instr = 0;
        for (int c = 0; c < 30000 && instr < 1000; c++) begin
            ir_in = 16'($urandom);
            exec_done = ($urandom_range(0, 2) == 0);
            prev = m_ph;
            tick();
            if (prev == P_EXEC && m_ph == P_T0) instr++;
        end
        check("random_budget", 32'(instr), 32'd1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
